// File: rtl/manual_drive_ctrl_gen2.sv
// Second-generation manual-transmission driving controller: power/start FSM,
// clutch-gated gearbox, tick-based speed and mileage, and blinking turn lamps.
module manual_drive_ctrl_gen2 #(
  parameter int NUM_GEARS  = 4,
  parameter int SPEED_W    = 8,
  parameter int GEAR_STEP  = 16,
  parameter int MILE_W     = 16,
  parameter int PWR_HOLD   = 100_000_000,
  parameter int BLINK_HALF = 50_000_000,
  parameter int ACC_DIV    = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power_btn,
  input  logic               throttle,
  input  logic               clutch,
  input  logic               brake,
  input  logic               reverse,
  input  logic               gear_up,
  input  logic               gear_down,
  input  logic               turn_left,
  input  logic               turn_right,
  output logic [3:0]         state,
  output logic               power_on,
  output logic [3:0]         motion,
  output logic [2:0]         gear,
  output logic [SPEED_W-1:0] speed,
  output logic [MILE_W-1:0]  mileage,
  output logic               lamp_l,
  output logic               lamp_r
);

  typedef enum logic [3:0] {
    ST_UNSTARTED = 4'b0001,
    ST_STARTING  = 4'b0010,
    ST_MOVING    = 4'b0100,
    ST_POWER_OFF = 4'b1000
  } state_t;

  localparam int TICK_W  = (ACC_DIV > 1) ? $clog2(ACC_DIV) : 1;
  localparam int HOLD_W  = $clog2(PWR_HOLD + 1);
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(ACC_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(PWR_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [2:0]         GEAR_MAX   = 3'(NUM_GEARS);
  localparam logic [31:0]        SPEED_MAX  = 32'((64'd1 << SPEED_W) - 64'd1);
  localparam logic [SPEED_W-1:0] SPD_ONE    = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] SPD_BRAKE  = SPEED_W'(4);

  state_t              state_r;
  state_t              next_state_s;
  logic                power_on_r;
  logic                btn_d_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [2:0]          gear_r;
  logic [SPEED_W-1:0]  speed_r;
  logic [MILE_W-1:0]   mileage_r;
  logic                rev_latch_r;
  logic [BLINK_W-1:0]  blink_cnt_r;
  logic                blink_dark_r;
  logic                pwr_rise_s;
  logic                hold_fire_s;
  logic                tick_s;
  logic                gear_ok_s;
  logic                blink_act_s;
  logic [31:0]         ceil_prod_s;
  logic [SPEED_W-1:0]  ceiling_s;
  logic [SPEED_W-1:0]  speed_next_s;
  logic [3:0]          motion_s;

  assign pwr_rise_s  = power_btn & ~btn_d_r;
  assign hold_fire_s = power_btn && (state_r != ST_POWER_OFF) && (hold_cnt_r == HOLD_LAST);
  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign gear_ok_s   = clutch && (gear_up ^ gear_down) &&
                       ((state_r == ST_STARTING) || (state_r == ST_MOVING));
  assign blink_act_s = (state_r != ST_POWER_OFF) && (turn_left || turn_right);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_POWER_OFF;
    else     state_r <= next_state_s;
  end

  // Next-state logic; the long-press power-off outranks every drive transition
  always_comb begin
    next_state_s = state_r;
    if (state_r == ST_POWER_OFF) begin
      if (pwr_rise_s) next_state_s = ST_UNSTARTED;
      else            next_state_s = ST_POWER_OFF;
    end else if (hold_fire_s) begin
      next_state_s = ST_POWER_OFF;
    end else begin
      case (state_r)
        ST_UNSTARTED: begin
          if (throttle && !clutch && !brake)     next_state_s = ST_POWER_OFF;
          else if (throttle && clutch && !brake) next_state_s = ST_STARTING;
          else                                   next_state_s = ST_UNSTARTED;
        end
        ST_STARTING: begin
          if (brake)                   next_state_s = ST_UNSTARTED;
          else if (!clutch && throttle) next_state_s = ST_MOVING;
          else                         next_state_s = ST_STARTING;
        end
        ST_MOVING: begin
          if (brake && speed_r == '0)                   next_state_s = ST_UNSTARTED;
          else if (!clutch && (reverse != rev_latch_r)) next_state_s = ST_POWER_OFF;
          else if (clutch)                              next_state_s = ST_STARTING;
          else if (!throttle && speed_r == '0)          next_state_s = ST_STARTING;
          else                                          next_state_s = ST_MOVING;
        end
        default: next_state_s = ST_POWER_OFF;
      endcase
    end
  end

  // Power button edge detect, long-press counter and registered power flag
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_d_r    <= 1'b0;
      hold_cnt_r <= '0;
      power_on_r <= 1'b0;
    end else begin
      btn_d_r    <= power_btn;
      power_on_r <= (next_state_s != ST_POWER_OFF);
      if ((state_r == ST_POWER_OFF) || !power_btn || hold_fire_s) hold_cnt_r <= '0;
      else                                                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
    end
  end

  // Per-tick speed update; a downshift above the new ceiling bleeds off one step per tick
  always_comb begin
    ceil_prod_s = 32'(gear_r) * 32'(GEAR_STEP);
    if (ceil_prod_s > SPEED_MAX) ceiling_s = SPEED_MAX[SPEED_W-1:0];
    else                         ceiling_s = ceil_prod_s[SPEED_W-1:0];
    speed_next_s = speed_r;
    if ((state_r == ST_MOVING) && throttle && !clutch && !brake) begin
      if (speed_r > ceiling_s)      speed_next_s = speed_r - SPD_ONE;
      else if (speed_r < ceiling_s) speed_next_s = speed_r + SPD_ONE;
      else                          speed_next_s = speed_r;
    end else if (brake) begin
      if (speed_r >= SPD_BRAKE) speed_next_s = speed_r - SPD_BRAKE;
      else                      speed_next_s = '0;
    end else if (speed_r != '0) begin
      speed_next_s = speed_r - SPD_ONE;
    end else begin
      speed_next_s = '0;
    end
  end

  // Tick divider, gearbox, speed, mileage and reverse latch
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r  <= '0;
      gear_r      <= 3'd1;
      speed_r     <= '0;
      mileage_r   <= '0;
      rev_latch_r <= 1'b0;
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TICK_ONE;
      if (next_state_s == ST_POWER_OFF)                      gear_r <= 3'd1;
      else if (gear_ok_s && gear_up && (gear_r < GEAR_MAX))  gear_r <= gear_r + 3'd1;
      else if (gear_ok_s && gear_down && (gear_r > 3'd1))    gear_r <= gear_r - 3'd1;
      if ((next_state_s == ST_POWER_OFF) || (next_state_s == ST_UNSTARTED)) speed_r <= '0;
      else if (tick_s)                                                      speed_r <= speed_next_s;
      if (tick_s) mileage_r <= mileage_r + MILE_W'(speed_r);
      if ((state_r == ST_STARTING) && !brake && !clutch) rev_latch_r <= reverse;
    end
  end

  // Shared blink phase so both lamps flash together in hazard mode
  always_ff @(posedge clk) begin
    if (rst || !blink_act_s) begin
      blink_cnt_r  <= '0;
      blink_dark_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r  <= '0;
      blink_dark_r <= ~blink_dark_r;
    end else begin
      blink_cnt_r  <= blink_cnt_r + BLINK_ONE;
    end
  end

  // Motion decode: only MOVING drives the chassis
  always_comb begin
    motion_s = 4'b0000;
    if (state_r == ST_MOVING) begin
      motion_s[0] = ~rev_latch_r & (speed_r != '0);
      motion_s[1] =  rev_latch_r & (speed_r != '0);
      motion_s[2] = turn_right & ~turn_left;
      motion_s[3] = turn_left & ~turn_right;
    end else begin
      motion_s = 4'b0000;
    end
  end

  assign state    = state_r;
  assign power_on = power_on_r;
  assign gear     = gear_r;
  assign speed    = speed_r;
  assign mileage  = mileage_r;
  assign motion   = motion_s;
  assign lamp_l   = power_on_r & turn_left  & ~blink_dark_r;
  assign lamp_r   = power_on_r & turn_right & ~blink_dark_r;

endmodule

// File: tb/tb_manual_drive_ctrl_gen2.sv
// Directed bench for manual_drive_ctrl_gen2: a vector table for power/FSM/gearbox
// steps plus hand sequences for speed, stall, long-press, lamps and reset.
module tb_manual_drive_ctrl_gen2;

  logic        clk = 1'b0;
  logic        rst, power_btn, throttle, clutch, brake, reverse;
  logic        gear_up, gear_down, turn_left, turn_right;
  logic [3:0]  state, motion;
  logic        power_on, lamp_l, lamp_r;
  logic [2:0]  gear;
  logic [7:0]  speed;
  logic [15:0] mileage;
  logic [15:0] m0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  manual_drive_ctrl_gen2 #(
    .NUM_GEARS(4), .SPEED_W(8), .GEAR_STEP(16), .MILE_W(16),
    .PWR_HOLD(8), .BLINK_HALF(4), .ACC_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .power_btn(power_btn), .throttle(throttle),
    .clutch(clutch), .brake(brake), .reverse(reverse), .gear_up(gear_up),
    .gear_down(gear_down), .turn_left(turn_left), .turn_right(turn_right),
    .state(state), .power_on(power_on), .motion(motion), .gear(gear),
    .speed(speed), .mileage(mileage), .lamp_l(lamp_l), .lamp_r(lamp_r)
  );

  typedef struct {
    logic       btn, thr, clu, brk, up, dn;
    logic [3:0] e_state;
    logic       e_pwr;
    logic [2:0] e_gear;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_speed_eq(input string name, input logic [7:0] target, input int budget);
    int n = 0;
    while (speed != target && n < budget) begin
      step();
      n++;
    end
    chk(name, {24'd0, speed}, {24'd0, target});
  endtask

  task automatic wait_speed_ge(input string name, input logic [7:0] target, input int budget);
    int n = 0;
    while (speed < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (speed < target) begin
      errors++;
      $display("FAIL %s: got speed %0d, expected at least %0d", name, speed, target);
    end
  endtask

  task automatic wait_state(input string name, input logic [3:0] target, input int budget);
    int n = 0;
    while (state != target && n < budget) begin
      step();
      n++;
    end
    chk(name, {28'd0, state}, {28'd0, target});
  endtask

  initial begin
    rst = 1'b1; power_btn = 1'b0; throttle = 1'b0; clutch = 1'b0; brake = 1'b0;
    reverse = 1'b0; gear_up = 1'b0; gear_down = 1'b0; turn_left = 1'b0; turn_right = 1'b0;

    //            btn   thr   clu   brk   up    dn    state    pwr   gear
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 3'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 3'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 3'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd4};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 3'd4};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd4};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 3'd4};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd1};

    step();
    step();
    chk("reset_state", {28'd0, state}, 32'h8);
    chk("reset_outs", {power_on, gear, speed, motion, lamp_l, lamp_r}, {1'b0, 3'd1, 8'd0, 4'd0, 1'b0, 1'b0});
    chk("reset_mileage", {16'd0, mileage}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      power_btn = vecs[i].btn; throttle = vecs[i].thr; clutch = vecs[i].clu;
      brake = vecs[i].brk; gear_up = vecs[i].up; gear_down = vecs[i].dn;
      step();
      chk($sformatf("vec%0d", i), {state, power_on, gear, speed, motion},
          {vecs[i].e_state, vecs[i].e_pwr, vecs[i].e_gear, 8'd0, 4'd0});
    end
    gear_up = 1'b0; gear_down = 1'b0;

    // Start forward, climb to the gear-1 ceiling and hold there
    power_btn = 1'b0; throttle = 1'b1; clutch = 1'b1; step();
    chk("start_starting", {28'd0, state}, 32'h2);
    clutch = 1'b0; step();
    chk("start_moving", {28'd0, state}, 32'h4);
    wait_speed_ge("first_tick", 8'd1, 4);
    chk("fwd_motion", {28'd0, motion}, 32'h1);
    wait_speed_eq("climb_g1", 8'd16, 100);
    repeat (20) step();
    chk("hold_g1", {24'd0, speed}, 32'd16);
    m0 = mileage;
    repeat (10) step();
    chk("mileage_5ticks", {16'd0, mileage - m0}, 32'd80);

    turn_left = 1'b1; step();
    chk("motion_left", {28'd0, motion}, 32'h9);
    turn_right = 1'b1; step();
    chk("motion_both", {28'd0, motion}, 32'h1);
    turn_left = 1'b0; turn_right = 1'b0; step();
    turn_left = 1'b1; turn_right = 1'b1; #1;
    chk("hazard_k0", {30'd0, lamp_l, lamp_r}, 32'h3);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("hazard_k%0d", k), {30'd0, lamp_l, lamp_r},
          (((k / 4) % 2) == 0) ? 32'h3 : 32'h0);
    end
    turn_left = 1'b0; #1;
    chk("lamp_drop", {31'd0, lamp_l}, 32'd0);
    turn_right = 1'b0;

    // Upshift under clutch, then climb to the gear-2 ceiling
    clutch = 1'b1; gear_up = 1'b1; step();
    chk("shift_up", {state, 1'b0, gear}, {4'b0010, 1'b0, 3'd2});
    gear_up = 1'b0; clutch = 1'b0; step();
    chk("reengage", {28'd0, state}, 32'h4);
    wait_speed_eq("climb_g2", 8'd32, 200);
    repeat (10) step();
    chk("hold_g2", {24'd0, speed}, 32'd32);

    // Downshift with speed above the new ceiling bleeds back to 16
    clutch = 1'b1; gear_down = 1'b1; step();
    chk("shift_down", {29'd0, gear}, 32'd1);
    gear_down = 1'b0; clutch = 1'b0; step();
    wait_speed_eq("bleed_g1", 8'd16, 200);
    repeat (10) step();
    chk("settle_g1", {24'd0, speed}, 32'd16);

    // Lever into reverse without clutch stalls the engine
    reverse = 1'b1; turn_left = 1'b1; step();
    chk("stall_rev", {state, power_on, gear, speed, motion, lamp_l},
        {4'b1000, 1'b0, 3'd1, 8'd0, 4'd0, 1'b0});
    turn_left = 1'b0;

    // Reverse driving, then lever change with clutch held is safe
    power_btn = 1'b1; throttle = 1'b0; step();
    power_btn = 1'b0; throttle = 1'b1; clutch = 1'b1; step();
    clutch = 1'b0; step();
    chk("rev_moving", {28'd0, state}, 32'h4);
    wait_speed_ge("rev_speed", 8'd1, 4);
    chk("back_motion", {28'd0, motion}, 32'h2);
    clutch = 1'b1; reverse = 1'b0; step();
    chk("rev_clutch", {27'd0, state, power_on}, {27'd0, 4'b0010, 1'b1});
    clutch = 1'b0; step();
    wait_speed_ge("fwd_again", 8'd2, 20);
    chk("fwd_motion2", {28'd0, motion}, 32'h1);

    // Brake down to standstill drops back to UNSTARTED
    throttle = 1'b0; brake = 1'b1;
    wait_state("brake_stop", 4'b0001, 40);
    chk("brake_speed", {24'd0, speed}, 32'd0);
    brake = 1'b0;

    // Gearbox saturation and rejected pulses
    throttle = 1'b1; clutch = 1'b1; step();
    throttle = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gear_up = 1'b1; step();
      gear_up = 1'b0; step();
    end
    chk("gear_sat", {29'd0, gear}, 32'd4);
    clutch = 1'b0; gear_down = 1'b1; step();
    gear_down = 1'b0;
    chk("gear_no_clutch", {29'd0, gear}, 32'd4);
    clutch = 1'b1; gear_up = 1'b1; gear_down = 1'b1; step();
    gear_up = 1'b0; gear_down = 1'b0; clutch = 1'b0;
    chk("gear_both", {29'd0, gear}, 32'd4);

    // Long press: PWR_HOLD-1 cycles stays on, PWR_HOLD forces off
    power_btn = 1'b1;
    repeat (7) step();
    chk("hold_minus1", {27'd0, state, power_on}, {27'd0, 4'b0010, 1'b1});
    step();
    chk("hold_off", {24'd0, state, power_on, gear}, {24'd0, 4'b1000, 1'b0, 3'd1});
    power_btn = 1'b0; step();
    chk("hold_stays_off", {28'd0, state}, 32'h8);

    // Synchronous reset mid-MOVING
    power_btn = 1'b1; step();
    power_btn = 1'b0; throttle = 1'b1; clutch = 1'b1; step();
    gear_up = 1'b1; step();
    gear_up = 1'b0; clutch = 1'b0; step();
    wait_speed_ge("pre_reset", 8'd3, 20);
    turn_left = 1'b1; step();
    rst = 1'b1; step();
    chk("mid_reset", {state, power_on, gear, speed, motion, lamp_l, lamp_r},
        {4'b1000, 1'b0, 3'd1, 8'd0, 4'd0, 1'b0, 1'b0});
    chk("mid_reset_mileage", {16'd0, mileage}, 32'd0);
    rst = 1'b0; throttle = 1'b0; turn_left = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/manual_drive_ctrl_gen2.md
Name: manual_drive_ctrl_gen2

Overview:
Second-generation manual-transmission driving controller for the car-simulator top level. It adds to the single-speed controller:
- a parametrised multi-gear gearbox with clutch-gated shifting;
- a speed accumulator and a mileage counter;
- a long-press power button;
- blinking turn lamps.

Its motion and lamp outputs drive the chassis/motor interface and the seven-segment/LED display blocks.

Parameters:
NUM_GEARS, 4, forward gears 1..NUM_GEARS (2..7)
SPEED_W, 8, speed register width
GEAR_STEP, 16, speed ceiling per gear: ceiling = gear*GEAR_STEP, saturating at 2^SPEED_W-1
MILE_W, 16, mileage counter width
PWR_HOLD, 100_000_000, power_btn high cycles to force power-off
BLINK_HALF, 50_000_000, turn-lamp half period in cycles
ACC_DIV, 1_000_000, cycles per speed update tick

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous active-high reset
power_btn  in  1  level, debounced upstream
throttle  in  1  level
clutch  in  1  level
brake  in  1  level
reverse  in  1  gear lever in reverse
gear_up  in  1  single-cycle pulse
gear_down  in  1  single-cycle pulse
turn_left  in  1  level
turn_right  in  1  level
state  out  4  one-hot: 0001 UNSTARTED, 0010 STARTING, 0100 MOVING, 1000 POWER_OFF
power_on  out  1  1 = powered
motion  out  4  {left,right,back,fwd}
gear  out  3  current forward gear, 1..NUM_GEARS
speed  out  SPEED_W  current speed
mileage  out  MILE_W  accumulated distance, wraps
lamp_l  out  1  left lamp
lamp_r  out  1  right lamp

Behaviour:
Reset:
- Synchronous, active-high; applies from any state, mid-operation.
- Reset values: state=POWER_OFF, power_on=0, gear=1, speed=0, mileage=0, lamps=0, motion=0, all counters cleared.

Power:
- In POWER_OFF, a rising edge of power_btn moves to UNSTARTED the next cycle.
- In any powered state, power_btn held high for PWR_HOLD consecutive cycles forces POWER_OFF.
- The hold counter clears whenever power_btn is low. The rising edge that powers on does not count toward the hold.
- power_on is registered and equals (state!=POWER_OFF).

FSM transitions, evaluated each cycle while powered, in priority order:
- UNSTARTED:
  - throttle & ~clutch & ~brake -> POWER_OFF (stall).
  - throttle & clutch & ~brake -> STARTING.
  - Otherwise stay.
- STARTING:
  - brake -> UNSTARTED.
  - ~clutch & throttle -> MOVING, latching reverse into rev_latch.
  - ~clutch & ~throttle -> stay, updating rev_latch.
  - clutch -> stay.
- MOVING:
  - brake & speed==0 -> UNSTARTED.
  - ~clutch & reverse!=rev_latch -> POWER_OFF (lever moved without clutch).
  - clutch -> STARTING.
  - ~throttle & speed==0 -> STARTING.
  - Otherwise stay.

Gearbox:
- gear_up or gear_down is accepted only when clutch=1 and the state is STARTING or MOVING; it is ignored otherwise.
- gear saturates at 1 and NUM_GEARS.
- Simultaneous up and down pulses are ignored.
- gear resets to 1 on entry to POWER_OFF.

Speed, updated once per ACC_DIV tick:
- In MOVING with throttle & ~clutch & ~brake: speed += 1, capped at the current gear ceiling.
- If the ceiling is below speed after a downshift: speed -= 1 per tick until it is at or below the ceiling.
- brake: speed -= 4, floor 0.
- Otherwise, in MOVING/STARTING: speed -= 1, floor 0.
- speed is forced to 0 in UNSTARTED/POWER_OFF.
- mileage += speed on every tick, modulo 2^MILE_W.

Motion, combinational from state and inputs:
- STARTING, UNSTARTED, POWER_OFF: motion=0000.
- MOVING:
  - fwd = ~rev_latch & speed!=0.
  - back = rev_latch & speed!=0.
  - left = turn_left & ~turn_right.
  - right = turn_right & ~turn_left.
  - Both turn inputs high means straight.

Lamps:
- Any powered state: lamp_l toggles every BLINK_HALF cycles while turn_left is high, likewise lamp_r with turn_right.
- A lamp goes low immediately when its input drops. When both inputs are high, both lamps blink in phase (hazard).
- Lamps are 0 when powered off.

Test Plan:
- Reset, then power_btn pulse -> state=0001, power_on=1, gear=1, speed=0 on the following cycle.
- UNSTARTED, throttle=1, clutch=0 -> state=1000, power_on=0 next cycle.
- Start: clutch+throttle -> 0010; release clutch with throttle, reverse=0 -> 0100, fwd=1 after the first tick. Speed climbs to 16 in gear 1 and holds at 16. Shift to gear 2 under clutch -> speed climbs to 32.
- In MOVING, toggle reverse with clutch=0 -> state=1000, gear=1, speed=0. Repeat with clutch=1 -> state=0010, no stall.
- Gear pulses: gear_up x8 with clutch=1 -> gear=NUM_GEARS (4). gear_up with clutch=0 -> unchanged. up and down pulses in the same cycle -> unchanged.
- Hold power_btn for PWR_HOLD-1 cycles -> still powered; for PWR_HOLD cycles -> POWER_OFF. Both turn inputs high with BLINK_HALF=4 -> lamp_l=lamp_r toggle in phase every 4 cycles. rst asserted mid-MOVING -> every output at its reset value on the next edge.
